// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel-rate divider, h/v counters and a registered
// output stage that keeps sync and color aligned one pixel behind the counters.
module vga_scan_timing #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        color_in,
    output logic signed [15:0] pix_x,
    output logic signed [15:0] pix_y,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          pix_tick;
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          hs_act;
    logic          vs_act;

    assign pix_tick = (div_cnt == DIV_LAST);
    assign h_last   = (h_cnt == H_LAST);
    assign v_last   = (v_cnt == V_LAST);
    assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_act   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_act   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    assign pix_x = {{(16-HW){1'b0}}, h_cnt};
    assign pix_y = {{(16-VW){1'b0}}, v_cnt};

    // Output stage samples the pre-increment counters, so it trails them by one pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                div_cnt <= '0;
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
                {vga_r, vga_g, vga_b} <= visible ? color_in : 12'h000;
                hsync       <= ~hs_act;
                vsync       <= ~vs_act;
                frame_start <= h_last && v_last;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: a default-size instance for line,
// color and latency behaviour, plus a shrunken instance for frame timing.
module tb_vga_scan_timing;

    logic        clk;
    logic        reset;
    logic        use_lat;
    logic [11:0] lat_color;
    logic [11:0] color_in;

    logic signed [15:0] pix_x, pix_y;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;
    logic [11:0] rgb;

    logic signed [15:0] sm_x, sm_y;
    logic [3:0]  sm_r, sm_g, sm_b;
    logic        sm_hs, sm_vs, sm_fs;
    logic [11:0] sm_rgb;

    int checks;
    int failures;

    vga_scan_timing u_dut (
        .clk(clk), .reset(reset), .color_in(color_in),
        .pix_x(pix_x), .pix_y(pix_y),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    // 16x9 pixel frame at 3 clks/pixel: line = 48 clks, frame = 432 clks.
    vga_scan_timing #(
        .CLK_DIV(3),
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .reset(reset), .color_in(12'hF0A),
        .pix_x(sm_x), .pix_y(sm_y),
        .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b),
        .hsync(sm_hs), .vsync(sm_vs), .frame_start(sm_fs)
    );

    assign rgb      = {vga_r, vga_g, vga_b};
    assign sm_rgb   = {sm_r, sm_g, sm_b};
    assign color_in = use_lat ? lat_color : 12'hF0A;

    // Upstream model with one clk of latency.
    always @(posedge clk) lat_color <= pix_x[11:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pix_x !== 16'sd0 || pix_y !== 16'sd0) begin
            failures++;
            $display("FAIL reset_pix: got x=%0d y=%0d expected 0 0", pix_x, pix_y);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++;
            $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", hsync, vsync);
        end
        checks++;
        if (rgb !== 12'h000 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_rgb_fs: got rgb=%h fs=%b expected 000 0", rgb, frame_start);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pix_x !== 16'sd0) begin
            failures++;
            $display("FAIL first_tick_early: got x=%0d expected 0", pix_x);
        end
        @(negedge clk);
        checks++;
        if (pix_x !== 16'sd1) begin
            failures++;
            $display("FAIL first_tick: got x=%0d expected 1", pix_x);
        end
    endtask

    task automatic test_line_timing();
        int wrap_k[$];
        int wrap_y[$];
        int fall_k[$];
        int rise_k[$];
        int prev_x;
        logic prev_hs;
        do_reset();
        prev_x  = 0;
        prev_hs = 1'b1;
        for (int k = 1; k <= 6404; k++) begin
            @(negedge clk);
            if (prev_x == 799 && pix_x == 0) begin
                wrap_k.push_back(k);
                wrap_y.push_back(int'(pix_y));
            end
            if (prev_hs && !hsync) fall_k.push_back(k);
            if (!prev_hs && hsync) rise_k.push_back(k);
            prev_x  = int'(pix_x);
            prev_hs = hsync;
        end
        checks++;
        if (wrap_k.size() != 2 || wrap_k[0] != 3200 || wrap_k[1] != 6400) begin
            failures++;
            $display("FAIL line_wrap: got n=%0d first=%0d expected 2 wraps at 3200,6400",
                     wrap_k.size(), (wrap_k.size() > 0) ? wrap_k[0] : -1);
        end
        checks++;
        if (wrap_y.size() != 2 || wrap_y[0] != 1 || wrap_y[1] != 2) begin
            failures++;
            $display("FAIL line_pix_y: got n=%0d expected y=1,2 after wraps", wrap_y.size());
        end
        checks++;
        if (fall_k.size() != 2 || fall_k[0] != 2628 || fall_k[1] != 5828) begin
            failures++;
            $display("FAIL hsync_fall: got n=%0d first=%0d expected 2628,5828",
                     fall_k.size(), (fall_k.size() > 0) ? fall_k[0] : -1);
        end
        checks++;
        if (rise_k.size() != 2 || rise_k[0] != 3012 || rise_k[1] != 6212) begin
            failures++;
            $display("FAIL hsync_width: got n=%0d first=%0d expected rises 3012,6212 (384 clks)",
                     rise_k.size(), (rise_k.size() > 0) ? rise_k[0] : -1);
        end
    endtask

    task automatic test_color_gating();
        int          ks[7] = '{3, 4, 2560, 2563, 2564, 3203, 3204};
        logic [11:0] ev[7] = '{12'h000, 12'hF0A, 12'hF0A, 12'hF0A, 12'h000, 12'h000, 12'hF0A};
        int idx;
        use_lat = 1'b0;
        do_reset();
        idx = 0;
        for (int k = 1; k <= 3204; k++) begin
            @(negedge clk);
            if (idx < 7 && k == ks[idx]) begin
                checks++;
                if (rgb !== ev[idx]) begin
                    failures++;
                    $display("FAIL color_gate k=%0d: got %h expected %h", k, rgb, ev[idx]);
                end
                idx++;
            end
        end
    endtask

    task automatic test_latency();
        int          ks[4] = '{4, 8, 2560, 2564};
        logic [11:0] ev[4] = '{12'h000, 12'h001, 12'h27F, 12'h000};
        int idx;
        use_lat = 1'b1;
        do_reset();
        idx = 0;
        for (int k = 1; k <= 2564; k++) begin
            @(negedge clk);
            if (idx < 4 && k == ks[idx]) begin
                checks++;
                if (rgb !== ev[idx]) begin
                    failures++;
                    $display("FAIL latency k=%0d: got %h expected %h", k, rgb, ev[idx]);
                end
                idx++;
            end
        end
        use_lat = 1'b0;
    endtask

    task automatic test_frame_timing();
        int fs_k[$];
        int vs_fall[$];
        int vs_rise[$];
        int fs_high;
        logic prev_vs;
        do_reset();
        fs_high = 0;
        prev_vs = 1'b1;
        for (int k = 1; k <= 900; k++) begin
            @(negedge clk);
            if (sm_fs) begin
                fs_high++;
                fs_k.push_back(k);
            end
            if (prev_vs && !sm_vs) vs_fall.push_back(k);
            if (!prev_vs && sm_vs) vs_rise.push_back(k);
            prev_vs = sm_vs;
            if (k == 432) begin
                checks++;
                if (sm_x !== 16'sd0 || sm_y !== 16'sd0) begin
                    failures++;
                    $display("FAIL frame_wrap: got x=%0d y=%0d expected 0 0", sm_x, sm_y);
                end
            end
            if (k == 168 || k == 171 || k == 195) begin
                checks++;
                if (sm_rgb !== ((k == 168) ? 12'hF0A : 12'h000)) begin
                    failures++;
                    $display("FAIL small_gate k=%0d: got %h", k, sm_rgb);
                end
            end
        end
        checks++;
        if (fs_high != 2 || fs_k.size() != 2 || fs_k[0] != 432 || fs_k[1] != 864) begin
            failures++;
            $display("FAIL frame_start: got high=%0d expected 2 single-clk pulses at 432,864", fs_high);
        end
        checks++;
        if (vs_fall.size() != 2 || vs_fall[0] != 243 || vs_fall[1] != 675) begin
            failures++;
            $display("FAIL vsync_fall: got n=%0d first=%0d expected 243,675",
                     vs_fall.size(), (vs_fall.size() > 0) ? vs_fall[0] : -1);
        end
        checks++;
        if (vs_rise.size() != 2 || vs_rise[0] != 339 || vs_rise[1] != 771) begin
            failures++;
            $display("FAIL vsync_width: got n=%0d first=%0d expected 339,771 (96 clks)",
                     vs_rise.size(), (vs_rise.size() > 0) ? vs_rise[0] : -1);
        end
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        repeat (4402) @(negedge clk);
        checks++;
        if (pix_x !== 16'sd300 || pix_y !== 16'sd1 || sm_hs !== 1'b0) begin
            failures++;
            $display("FAIL mid_setup: got x=%0d y=%0d sm_hs=%b expected 300 1 0",
                     pix_x, pix_y, sm_hs);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_x !== 16'sd0 || pix_y !== 16'sd0 || rgb !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset_pix: got x=%0d y=%0d rgb=%h expected 0 0 000",
                     pix_x, pix_y, rgb);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || frame_start !== 1'b0 || sm_hs !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_sync: got hs=%b vs=%b fs=%b sm_hs=%b expected 1 1 0 1",
                     hsync, vsync, frame_start, sm_hs);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pix_x !== 16'sd1) begin
            failures++;
            $display("FAIL mid_restart: got x=%0d expected 1", pix_x);
        end
        repeat (28) @(negedge clk);
        checks++;
        if (sm_hs !== 1'b1) begin
            failures++;
            $display("FAIL mid_restart_hs_early: got %b expected 1", sm_hs);
        end
        @(negedge clk);
        checks++;
        if (sm_hs !== 1'b0) begin
            failures++;
            $display("FAIL mid_restart_hs: got %b expected 0", sm_hs);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        use_lat  = 1'b0;
        test_reset();
        test_line_timing();
        test_color_gating();
        test_latency();
        test_frame_timing();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
